// File: rtl/rs485_frame_link_if.sv
// Application and line-side signals of the RS485 frame link, bundled for port connection.
// Latency: none (wiring only).
// Backpressure: none; tx_req is dropped by the link while tx_busy is high.
interface rs485_frame_link_if #(
  parameter int DATA_W = 16
) ();
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_err;
  logic              rs485_uart_rxd;
  logic              rs485_uart_txd;
  logic              rs485_tx_en;

  // Application / transceiver side
  modport master (
    output tx_req, tx_data, rs485_uart_rxd,
    input  tx_busy, rx_valid, rx_data, rx_err, rs485_uart_txd, rs485_tx_en
  );

  // Link controller side
  modport slave (
    input  tx_req, tx_data, rs485_uart_rxd,
    output tx_busy, rx_valid, rx_data, rx_err, rs485_uart_txd, rs485_tx_en
  );
endinterface

// File: rtl/rs485_frame_link.sv
// Half-duplex RS485 framed link: HEADER, payload MSB first, XOR checksum; 8N1 UART with driver-enable sequencing.
// Latency: tx_busy the cycle after tx_req; rx_valid/rx_err one cycle after the checksum stop-bit sample.
// Backpressure: none; tx_req outside TX idle is ignored, rx bytes arriving while transmitting are blanked.
module rs485_frame_link #(
  parameter int         CLK_FREQ        = 50000000,
  parameter int         UART_BPS        = 115200,
  parameter int         DATA_W          = 16,
  parameter int         GUARD_BITS      = 2,
  parameter logic [7:0] HEADER          = 8'h55,
  parameter int         RX_TIMEOUT_BITS = 20
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  rs485_frame_link_if.slave bus
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int NB      = DATA_W / 8;
  localparam int FW      = 8 * (NB + 2);
  localparam int TO_CLKS = RX_TIMEOUT_BITS * BPS_CNT;
  localparam int CNT_W   = $clog2(TO_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF   = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_CLKS - 1);
  localparam logic [3:0]       LAST_BYTE  = 4'(NB + 1);
  localparam logic [3:0]       NB_LAST    = 4'(NB - 1);
  localparam logic [7:0]       GUARD_END  = 8'(GUARD_BITS);
  localparam logic [7:0]       GUARD_LAST = 8'(GUARD_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_LEAD, TX_SEND, TX_GUARD} tx_state_t;
  typedef enum logic [1:0] {RX_WAIT_HDR, RX_PAYLOAD, RX_CHK} rx_state_t;

  // ---------------- transmit path ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]        tx_bit_q, tx_bit_d;
  logic [3:0]        tx_byte_idx_q, tx_byte_idx_d;
  logic [FW-1:0]     tx_frame_q, tx_frame_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic              txd_q, txd_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_chk;
  logic              tx_bit_end;

  // Checksum of the payload being offered, folded byte by byte
  always_comb begin
    tx_chk = '0;
    for (int i = 0; i < NB; i++) tx_chk = tx_chk ^ bus.tx_data[i*8 +: 8];
  end

  // TX sequencing: lead bit, framed bytes, guard bits, then one drain cycle with the driver released
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    tx_byte_idx_d = tx_byte_idx_q;
    tx_frame_d    = tx_frame_q;
    tx_sr_d       = tx_sr_q;
    txd_d         = txd_q;
    tx_en_d       = tx_en_q;
    tx_bit_end    = (tx_cnt_q == BIT_LAST);
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_req) begin
          tx_state_d = TX_LEAD;
          tx_frame_d = {HEADER, bus.tx_data, tx_chk};
          tx_cnt_d   = '0;
          tx_en_d    = 1'b1;
          txd_d      = 1'b1;
        end
      end
      TX_LEAD: begin
        if (tx_bit_end) begin
          tx_state_d    = TX_SEND;
          tx_byte_idx_d = '0;
          tx_bit_d      = '0;
          tx_sr_d       = tx_frame_q[FW-1 -: 8];
          tx_frame_d    = tx_frame_q << 8;
          txd_d         = 1'b0;
        end
      end
      TX_SEND: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 8'd9) begin
            tx_bit_d = '0;
            if (tx_byte_idx_q == LAST_BYTE) begin
              tx_state_d = TX_GUARD;
              txd_d      = 1'b1;
            end else begin
              tx_byte_idx_d = tx_byte_idx_q + 4'd1;
              tx_sr_d       = tx_frame_q[FW-1 -: 8];
              tx_frame_d    = tx_frame_q << 8;
              txd_d         = 1'b0;
            end
          end else if (tx_bit_q == 8'd8) begin
            tx_bit_d = tx_bit_q + 8'd1;
            txd_d    = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 8'd1;
            txd_d    = tx_sr_q[0];
            tx_sr_d  = tx_sr_q >> 1;
          end
        end
      end
      TX_GUARD: begin
        // tx_bit_q counts guard bits; reaching GUARD_END marks the drain cycle
        if (tx_bit_q == GUARD_END) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else if (tx_bit_end) begin
          tx_bit_d = tx_bit_q + 8'd1;
          if (tx_bit_q == GUARD_LAST) tx_en_d = 1'b0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_byte_idx_q <= '0;
      tx_frame_q    <= '0;
      tx_sr_q       <= '0;
      txd_q         <= 1'b1;
      tx_en_q       <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_byte_idx_q <= tx_byte_idx_d;
      tx_frame_q    <= tx_frame_d;
      tx_sr_q       <= tx_sr_d;
      txd_q         <= txd_d;
      tx_en_q       <= tx_en_d;
    end
  end

  // ---------------- receive path ----------------
  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic              rx_busy_q, rx_busy_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic              byte_ok, byte_ferr, rx_fall;
  rx_state_t         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_pay_q, rx_pay_d, rx_data_q, rx_data_d;
  logic [7:0]        rx_acc_q, rx_acc_d;
  logic [3:0]        rx_nbyte_q, rx_nbyte_d;
  logic [CNT_W-1:0]  rx_to_q, rx_to_d;
  logic              rx_valid_q, rx_valid_d, rx_err_q, rx_err_d, rx_timeout;

  // Byte receiver: synchronise, detect start while the driver is off, sample mid-bit
  always_comb begin
    rx_s1_d   = bus.rs485_uart_rxd;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    rx_fall   = rx_prev_q & ~rx_s2_q;
    rx_busy_d = rx_busy_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sr_d   = rx_sr_q;
    byte_ok   = 1'b0;
    byte_ferr = 1'b0;
    if (!rx_busy_q) begin
      if (rx_fall && !tx_en_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = '0;
        rx_bit_d  = '0;
      end
    end else if (tx_en_q) begin
      rx_busy_d = 1'b0;  // our own transmission blanks any byte in flight
    end else begin
      rx_cnt_d = (rx_cnt_q == BIT_LAST) ? '0 : rx_cnt_q + 1'b1;
      if (rx_cnt_q == BIT_LAST) rx_bit_d = rx_bit_q + 4'd1;
      if (rx_cnt_q == BIT_HALF) begin
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_busy_d = 1'b0;  // false start
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_d = 1'b0;
          byte_ok   = rx_s2_q;
          byte_ferr = ~rx_s2_q;
        end else begin
          rx_sr_d = {rx_s2_q, rx_sr_q[7:1]};
        end
      end
    end
  end

  // Frame assembly: header hunt, payload collection, checksum compare, inter-byte timeout
  always_comb begin
    rx_state_d = rx_state_q;
    rx_pay_d   = rx_pay_q;
    rx_acc_d   = rx_acc_q;
    rx_nbyte_d = rx_nbyte_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_to_d    = rx_to_q;
    rx_timeout = 1'b0;
    if (rx_state_q == RX_WAIT_HDR || byte_ok || byte_ferr) rx_to_d = '0;
    else if (!rx_busy_q) begin
      rx_to_d    = rx_to_q + 1'b1;
      rx_timeout = (rx_to_q == TO_LAST);
    end
    case (rx_state_q)
      RX_WAIT_HDR: begin
        if (byte_ok && rx_sr_q == HEADER) begin
          rx_state_d = RX_PAYLOAD;
          rx_nbyte_d = '0;
          rx_acc_d   = '0;
        end
      end
      RX_PAYLOAD: begin
        if (byte_ok) begin
          rx_pay_d   = (rx_pay_q << 8) | DATA_W'(rx_sr_q);
          rx_acc_d   = rx_acc_q ^ rx_sr_q;
          rx_nbyte_d = rx_nbyte_q + 4'd1;
          if (rx_nbyte_q == NB_LAST) rx_state_d = RX_CHK;
        end else if (byte_ferr || rx_timeout) begin
          rx_err_d   = 1'b1;
          rx_state_d = RX_WAIT_HDR;
        end
      end
      RX_CHK: begin
        if (byte_ok) begin
          rx_state_d = RX_WAIT_HDR;
          if (rx_sr_q == rx_acc_q) begin
            rx_data_d  = rx_pay_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else if (byte_ferr || rx_timeout) begin
          rx_err_d   = 1'b1;
          rx_state_d = RX_WAIT_HDR;
        end
      end
      default: rx_state_d = RX_WAIT_HDR;
    endcase
  end

  // RX state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sr_q    <= '0;
      rx_state_q <= RX_WAIT_HDR;
      rx_pay_q   <= '0;
      rx_acc_q   <= '0;
      rx_nbyte_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_to_q    <= '0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      rx_state_q <= rx_state_d;
      rx_pay_q   <= rx_pay_d;
      rx_acc_q   <= rx_acc_d;
      rx_nbyte_q <= rx_nbyte_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_to_q    <= rx_to_d;
    end
  end

  assign bus.tx_busy        = (tx_state_q != TX_IDLE);
  assign bus.rs485_uart_txd = txd_q;
  assign bus.rs485_tx_en    = tx_en_q;
  assign bus.rx_valid       = rx_valid_q;
  assign bus.rx_err         = rx_err_q;
  assign bus.rx_data        = rx_data_q;

endmodule

// File: tb/tb_rs485_frame_link.sv
// Two cross-wired link instances plus a line driver; a byte-level model predicts wire bytes and receive events.
// Bit time is shortened (16 clocks) so the whole run stays short; all frame arithmetic is scaled from it.
module tb_rs485_frame_link;
  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int DATA_W   = 16;
  localparam int NB       = DATA_W / 8;
  localparam int GUARD    = 2;
  localparam int TO_BITS  = 20;
  localparam int EN_CLKS  = (1 + 10 * (NB + 2) + GUARD) * BPS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n, bfm_line, b_from_bfm;
  logic [1:0] a_src;  // 0: B's txd, 1: own txd, 2: line driver

  rs485_frame_link_if #(.DATA_W(DATA_W)) ifa ();
  rs485_frame_link_if #(.DATA_W(DATA_W)) ifb ();

  rs485_frame_link #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_W(DATA_W), .GUARD_BITS(GUARD),
                     .HEADER(8'h55), .RX_TIMEOUT_BITS(TO_BITS))
    dut_a (.sys_clk(clk), .sys_rst_n(rst_a_n), .bus(ifa));
  rs485_frame_link #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_W(DATA_W), .GUARD_BITS(GUARD),
                     .HEADER(8'h55), .RX_TIMEOUT_BITS(TO_BITS))
    dut_b (.sys_clk(clk), .sys_rst_n(rst_b_n), .bus(ifb));

  assign ifa.rs485_uart_rxd = (a_src == 2'd1) ? ifa.rs485_uart_txd :
                              (a_src == 2'd2) ? bfm_line : ifb.rs485_uart_txd;
  assign ifb.rs485_uart_rxd = b_from_bfm ? bfm_line : ifa.rs485_uart_txd;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, a_vld_n = 0, a_err_n = 0, b_vld_n = 0, b_err_n = 0, both_hi = 0;
  int en_hi_n = 0, en_fall_cyc = 0, busy_fall_cyc = 0, b_err_cyc = 0;
  logic en_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] wire_q[$];
  logic [DATA_W-1:0] exp_b_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (ifa.rx_valid) a_vld_n++;
    if (ifa.rx_err) a_err_n++;
    if (ifb.rx_valid) b_vld_n++;
    if (ifb.rx_err) begin b_err_n++; b_err_cyc = cyc; end
    if ((ifa.rx_valid && ifa.rx_err) || (ifb.rx_valid && ifb.rx_err)) both_hi++;
    if (ifa.rs485_tx_en) en_hi_n++;
    if (en_prev && !ifa.rs485_tx_en) en_fall_cyc = cyc;
    if (busy_prev && !ifa.tx_busy) busy_fall_cyc = cyc;
    en_prev   = ifa.rs485_tx_en;
    busy_prev = ifa.tx_busy;
  end

  // Independent 8N1 decoder of A's transmit line
  initial begin : wire_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !ifa.rs485_uart_txd) begin
        repeat (BPS / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(negedge clk);
          b[i] = ifa.rs485_uart_txd;
        end
        repeat (BPS) @(negedge clk);
        wire_q.push_back(b);
      end
      prev = ifa.rs485_uart_txd;
    end
  end

  task automatic request_a(input logic [DATA_W-1:0] d);
    @(negedge clk);
    ifa.tx_req  = 1'b1;
    ifa.tx_data = d;
    @(negedge clk);
    ifa.tx_req  = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag);
    int n;
    n = 0;
    while (ifa.tx_busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    check(tag, 64'(n < 5000), 64'd1);
  endtask

  task automatic bfm_byte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bfm_line = bits[i];
      repeat (BPS) @(negedge clk);
    end
  endtask

  // Expected wire image: header, payload MSB first, XOR of payload bytes
  task automatic check_wire(input string tag, input logic [DATA_W-1:0] d);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'h55);
    for (int i = NB - 1; i >= 0; i--) begin
      exp_q.push_back(d[i*8 +: 8]);
      x = x ^ d[i*8 +: 8];
    end
    exp_q.push_back(x);
    check({tag, "_len"}, 64'(wire_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(wire_q[i]), 64'(exp_q[i]));
  endtask

  // A sends one frame to B; checks wire image and B's reception
  task automatic a_to_b(input string tag, input logic [DATA_W-1:0] d);
    int v0, e0;
    v0 = b_vld_n; e0 = b_err_n;
    wire_q.delete();
    request_a(d);
    wait_a_idle({tag, "_done"});
    repeat (3 * BPS) @(negedge clk);
    check_wire(tag, d);
    check({tag, "_bvld"}, 64'(b_vld_n - v0), 64'd1);
    check({tag, "_berr"}, 64'(b_err_n - e0), 64'd0);
    check({tag, "_bdata"}, 64'(ifb.rx_data), 64'(d));
    exp_b_data = d;
  endtask

  initial begin : stim
    int v0, e0, mark, lat;
    logic [DATA_W-1:0] d;
    rst_a_n = 1'b0; rst_b_n = 1'b0; bfm_line = 1'b1; b_from_bfm = 1'b0; a_src = 2'd0;
    ifa.tx_req = 1'b0; ifa.tx_data = '0; ifb.tx_req = 1'b0; ifb.tx_data = '0;
    exp_b_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(ifa.rs485_uart_txd), 64'd1);
    check("rst_en", 64'(ifa.rs485_tx_en), 64'd0);
    check("rst_busy", 64'(ifa.tx_busy), 64'd0);
    check("rst_vld_err", 64'({ifa.rx_valid, ifa.rx_err}), 64'd0);
    check("rst_rxdata", 64'(ifb.rx_data), 64'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame, driver-enable window and busy release order
    en_hi_n = 0;
    a_to_b("f_a53c", 16'hA53C);
    check("en_clks", 64'(en_hi_n), 64'(EN_CLKS));
    check("busy_after_en", 64'(busy_fall_cyc - en_fall_cyc), 64'd1);

    // Randomised payloads
    for (int k = 0; k < 3; k++) a_to_b($sformatf("rnd%0d", k), DATA_W'($urandom));

    // A request during a frame is dropped, not queued
    d = DATA_W'($urandom);
    en_hi_n = 0;
    wire_q.delete();
    request_a(d);
    repeat (10 * BPS) @(negedge clk);
    request_a(16'hDEAD);
    wait_a_idle("mid_done");
    repeat (30 * BPS) @(negedge clk);
    check("mid_en_clks", 64'(en_hi_n), 64'(EN_CLKS));
    check_wire("mid_frame", d);
    a_to_b("f_0001", 16'h0001);

    // Bad checksum from the line driver
    b_from_bfm = 1'b1;
    v0 = b_vld_n; e0 = b_err_n;
    bfm_byte(8'h55); bfm_byte(8'h12); bfm_byte(8'h34); bfm_byte(8'h00);
    repeat (5 * BPS) @(negedge clk);
    check("badchk_err", 64'(b_err_n - e0), 64'd1);
    check("badchk_vld", 64'(b_vld_n - v0), 64'd0);
    check("badchk_hold", 64'(ifb.rx_data), 64'(exp_b_data));

    // Inter-byte timeout, then a good frame
    v0 = b_vld_n; e0 = b_err_n;
    bfm_byte(8'h55); bfm_byte(8'h12);
    mark = cyc;
    repeat (25 * BPS) @(negedge clk);
    lat = b_err_cyc - mark;
    check("to_err", 64'(b_err_n - e0), 64'd1);
    check("to_lat_window", 64'(lat >= (TO_BITS - 1) * BPS && lat <= (TO_BITS + 1) * BPS), 64'd1);
    check("to_vld", 64'(b_vld_n - v0), 64'd0);
    v0 = b_vld_n; e0 = b_err_n;
    bfm_byte(8'h55); bfm_byte(8'h12); bfm_byte(8'h34); bfm_byte(8'h26);
    repeat (3 * BPS) @(negedge clk);
    check("after_to_vld", 64'(b_vld_n - v0), 64'd1);
    check("after_to_err", 64'(b_err_n - e0), 64'd0);
    check("after_to_data", 64'(ifb.rx_data), 64'h1234);

    // Own echo is blanked; a non-header byte and a short glitch are ignored
    a_src = 2'd1;
    v0 = a_vld_n; e0 = a_err_n;
    request_a(16'hFFFF);
    wait_a_idle("echo_done");
    repeat (5 * BPS) @(negedge clk);
    check("echo_vld", 64'(a_vld_n - v0), 64'd0);
    check("echo_err", 64'(a_err_n - e0), 64'd0);
    a_src = 2'd2;
    bfm_byte(8'hAA);
    bfm_line = 1'b0;
    repeat (BPS / 3) @(negedge clk);
    bfm_line = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    bfm_byte(8'h55); bfm_byte(8'h00); bfm_byte(8'h00); bfm_byte(8'h00);
    repeat (3 * BPS) @(negedge clk);
    check("glitch_vld", 64'(a_vld_n - v0), 64'd1);
    check("glitch_err", 64'(a_err_n - e0), 64'd0);
    check("glitch_data", 64'(ifa.rx_data), 64'd0);

    // Reset in the middle of the payload
    a_src = 2'd0; b_from_bfm = 1'b0;
    repeat (2 * BPS) @(negedge clk);
    v0 = b_vld_n; e0 = b_err_n;
    request_a(DATA_W'($urandom));
    repeat (16 * BPS) @(negedge clk);
    rst_a_n = 1'b0;
    @(negedge clk);
    check("rst_mid_txd", 64'(ifa.rs485_uart_txd), 64'd1);
    check("rst_mid_en", 64'(ifa.rs485_tx_en), 64'd0);
    check("rst_mid_busy", 64'(ifa.tx_busy), 64'd0);
    rst_a_n = 1'b1;
    repeat (35 * BPS) @(negedge clk);
    check("rst_mid_berr", 64'(b_err_n - e0), 64'd1);
    check("rst_mid_bvld", 64'(b_vld_n - v0), 64'd0);
    a_to_b("post_rst", DATA_W'($urandom));

    check("never_both", 64'(both_hi), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rs485_frame_link.md
Name: rs485_frame_link

Overview:
Parametrised half-duplex RS485 link controller. It replaces the single-byte, raw-UART key/LED exchange with framed multi-byte transfers of DATA_W bits, each protected by a header and an XOR checksum. It contains its own bit-level UART TX/RX, RS485 driver-enable sequencing (lead and guard times) and receive blanking while transmitting. It sits between application logic (key scanners, LED/register controllers) and the RS485 transceiver pins.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit (integer division)
DATA_W, 16, payload width in bits; must be a multiple of 8, range 8..64; NB = DATA_W/8 payload bytes
GUARD_BITS, 2, bit times rs485_tx_en stays high after the last stop bit
HEADER, 8'h55, frame start byte
RX_TIMEOUT_BITS, 20, idle bit times allowed between bytes inside a frame

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset, synchronous, active-low
tx_req  input  1  one-cycle request to send tx_data as one frame
tx_data  input  DATA_W  payload to send
tx_busy  output  1  high while a frame is in progress
rx_valid  output  1  one-cycle pulse: good frame received, rx_data updated
rx_data  output  DATA_W  last good payload received
rx_err  output  1  one-cycle pulse: framing, checksum or timeout error
rs485_uart_rxd  input  1  RS485 receive line (asynchronous)
rs485_uart_txd  output  1  RS485 transmit line, idle high
rs485_tx_en  output  1  RS485 driver enable, active high

Behaviour:
- One clock, sys_clk. Reset is synchronous and active-low on sys_rst_n.
- Reset values: rs485_uart_txd=1, rs485_tx_en=0, tx_busy=0, rx_valid=0, rx_err=0, rx_data=0. Both FSMs go to idle.
- Reset asserted mid-frame aborts immediately. The line returns to idle and the driver is released on the next clock edge. No partial rx_valid or rx_err is emitted.
- Frame on the wire: HEADER, payload bytes most-significant byte first, CHK = XOR of all payload bytes.
- Each byte is 8N1, LSB first, one start bit (0), one stop bit (1), each bit BPS_CNT clocks. Bytes are sent back-to-back.
- TX FSM states:
  - IDLE: accepts tx_req only here and latches tx_data on the request cycle. tx_req in any other state is ignored, not queued.
  - LEAD: rs485_tx_en=1 and txd=1 for one bit time.
  - SEND: NB+2 bytes.
  - GUARD: txd=1 and rs485_tx_en=1 for GUARD_BITS bit times.
  - Returns to IDLE.
- tx_busy rises the cycle after acceptance and falls on the cycle the TX FSM re-enters IDLE.
- rs485_tx_en is high for exactly (1 + 10*(NB+2) + GUARD_BITS)*BPS_CNT clocks.
- RX input path: rxd passes through a 2-flop synchroniser. A start bit is detected on a synchronised falling edge, only while rs485_tx_en=0; bytes are blanked while transmitting, so the block never receives its own echo.
- RX sampling: each bit is sampled at BPS_CNT/2 into the bit. A false start (sample=1 at mid-start) is ignored silently. A stop-bit sample of 0 is a framing error.
- RX frame FSM states:
  - WAIT_HDR: a non-HEADER byte is discarded with no error.
  - PAYLOAD: collects NB bytes.
  - CHK: on match, rx_data is updated and rx_valid pulses for one cycle, on the same cycle. On mismatch, rx_err pulses and rx_data is held.
  - Always returns to WAIT_HDR after CHK.
- RX errors:
  - Framing error in PAYLOAD or CHK: rx_err pulses and the FSM goes to WAIT_HDR.
  - Framing error in WAIT_HDR: silent drop.
  - Timeout: in PAYLOAD or CHK, if no start bit arrives within RX_TIMEOUT_BITS*BPS_CNT clocks after the previous stop sample, rx_err pulses and the FSM goes to WAIT_HDR.
  - rx_valid and rx_err are never high together.
- Simultaneous local tx_req during an incoming frame: TX starts and the RX bytes in flight are lost. If blanking truncates the frame, it ends through the timeout path.

Test Plan:
- Defaults, two instances cross-wired (A.txd to B.rxd, B.txd to A.rxd). A gets tx_req with tx_data=16'hA53C -> wire carries 55 A5 3C 99. B pulses rx_valid once with rx_data=16'hA53C. A's rs485_tx_en is high for 43*434=18662 clocks. tx_busy falls one cycle after rs485_tx_en.
- A second tx_req pulse mid-frame, then a new request after tx_busy=0 with 16'h0001 -> second frame is 55 00 01 01 only. The mid-frame request produces no extra frame.
- BFM drives 55 12 34 00 into rxd (bad CHK, correct is 26) -> rx_err pulses once, no rx_valid, rx_data holds its previous value.
- BFM drives 55 12 then goes idle for 25 bit times -> rx_err pulses 20 bit times after the last stop sample. A following 55 12 34 26 yields rx_valid with rx_data=16'h1234.
- rxd tied to own txd, tx_req with 16'hFFFF -> no rx_valid or rx_err. A byte AA, then a 100-clock low glitch, before 55 00 00 00 -> only rx_valid with rx_data=0.
- sys_rst_n low for 1 cycle in the middle of the TX payload -> next edge gives txd=1, rs485_tx_en=0, tx_busy=0. A new tx_req then sends a complete, correct frame.
